seg_scan_display: RTL and testbench

- Downstream consumer of the SoC's 16-bit LED/debug word.
- Time-multiplexes the word as four hex digits onto a common-anode 7-segment display.
- Double-buffers the incoming value so a new value never changes the display partway through a scan frame.
- Sits in the board top, between the SoC output and the FPGA pins.

---
 rtl/seg_scan_display.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_display.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Shows a 16-bit word as four hex digits on a common-anode 7-segment
//   display. One digit is driven at a time. A new word is held in a
//   pending register and copied to the display register only at a frame
//   boundary, so a frame never shows a mix of old and new digits.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   data_in     word to display; nibble i drives digit i (digit 0 = LSN)
//   data_valid  one-cycle strobe that captures data_in and dp_in
//   dp_in       decimal point for each digit, captured with data_in
//   an          digit enables, one-hot when active
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point of the active digit
//   frame_done  one-cycle pulse in the cycle after each frame boundary
//   pending     a captured word is waiting for the next frame boundary
//
// Optional feature
//   SEG_LEADING_ZERO_BLANK_EN: when defined, digits 3..1 are blanked while
//   that digit and all more-significant digits are zero. The anode is
//   still scanned for a blanked digit. Digit 0 is never blanked.
module seg_scan_display #(
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done,
    output logic        pending
);

    localparam int              CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic            INV       = (SEG_ACTIVE_LOW != 0);

    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [15:0]      display_reg;
    logic [3:0]       dp_reg;
    logic [15:0]      pend_data;
    logic [3:0]       pend_dp;
    logic             pend_flag;
    logic             boundary;

    logic [3:0]       digit_val;
    logic             lz_blank;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    // Active-high hex to {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hexdecode(input logic [3:0] v);
        case (v)
            4'h0: hexdecode = 7'b0111111;
            4'h1: hexdecode = 7'b0000110;
            4'h2: hexdecode = 7'b1011011;
            4'h3: hexdecode = 7'b1001111;
            4'h4: hexdecode = 7'b1100110;
            4'h5: hexdecode = 7'b1101101;
            4'h6: hexdecode = 7'b1111101;
            4'h7: hexdecode = 7'b0000111;
            4'h8: hexdecode = 7'b1111111;
            4'h9: hexdecode = 7'b1101111;
            4'hA: hexdecode = 7'b1110111;
            4'hB: hexdecode = 7'b1111100;
            4'hC: hexdecode = 7'b0111001;
            4'hD: hexdecode = 7'b1011110;
            4'hE: hexdecode = 7'b1111001;
            default: hexdecode = 7'b1110001;
        endcase
    endfunction

    assign boundary = (div_cnt == CNT_LAST) && (idx == 2'd3);
    assign pending  = pend_flag;

    // Slot timer and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else if (div_cnt == CNT_LAST) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Capture and frame-boundary transfer. A strobe that lands on the
    // boundary bypasses the pending register, so pend_flag ends cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_flag   <= 1'b0;
            display_reg <= '0;
            dp_reg      <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (data_valid) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
            end
            if (boundary) begin
                pend_flag <= 1'b0;
                if (data_valid) begin
                    display_reg <= data_in;
                    dp_reg      <= dp_in;
                end else if (pend_flag) begin
                    display_reg <= pend_data;
                    dp_reg      <= pend_dp;
                end
            end else if (data_valid) begin
                pend_flag <= 1'b1;
            end
        end
    end

    assign digit_val = display_reg[{idx, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank = 1'b0;
        case (idx)
            2'd3: lz_blank = (display_reg[15:12] == 4'h0);
            2'd2: lz_blank = (display_reg[15:8]  == 8'h00);
            2'd1: lz_blank = (display_reg[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Next-state outputs in active-high form; polarity applied at the register.
    always_comb begin
        an_next  = 4'b0000;
        seg_next = 7'b0000000;
        dp_next  = 1'b0;
        if (div_cnt >= BLANK_END) begin
            an_next = 4'b0001 << idx;
            if (!lz_blank) begin
                seg_next = hexdecode(digit_val);
                dp_next  = dp_reg[idx];
            end
        end
    end

    // Output register stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= {4{INV}};
            seg <= {7{INV}};
            dp  <= INV;
        end else begin
            an  <= an_next ^ {4{INV}};
            seg <= seg_next ^ {7{INV}};
            dp  <= dp_next ^ INV;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        data_valid;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        pending;

    int checks   = 0;
    int failures = 0;
    int cyc;

    // Active-low digit patterns and anode codes
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = BL;
`else
    localparam logic [6:0] LZ = S0;
`endif
    localparam logic [3:0] A0 = 4'b1110;
    localparam logic [3:0] A1 = 4'b1101;
    localparam logic [3:0] A2 = 4'b1011;
    localparam logic [3:0] A3 = 4'b0111;

    typedef struct {
        int         slot;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];

    seg_scan_display #(
        .SCAN_DIV(8),
        .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .data_valid(data_valid),
        .dp_in(dp_in),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_done(frame_done),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push(input int s, input logic [3:0] a, input logic [6:0] sg, input logic d);
        exp_t e;
        e.slot = s;
        e.an   = a;
        e.seg  = sg;
        e.dp   = d;
        q.push_back(e);
    endtask

    task automatic wait_edge(input int n);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < n);
    endtask

    task automatic strobe(input logic [15:0] d, input logic [3:0] p);
        data_in    = d;
        dp_in      = p;
        data_valid = 1'b1;
    endtask

    // Monitor: each new lit digit slot is matched against the queue head
    initial begin : monitor
        int   slot;
        logic prev_act;
        logic act;
        exp_t e;
        slot     = -1;
        prev_act = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                slot     = -1;
                prev_act = 1'b0;
            end else begin
                act = (an != 4'hF);
                if (act && !prev_act) begin
                    slot++;
                    while (q.size() > 0 && q[0].slot < slot) begin
                        e = q.pop_front();
                        chk($sformatf("slot%0d_missed", e.slot), 32'(slot), 32'(e.slot));
                    end
                    if (q.size() > 0 && q[0].slot == slot) begin
                        e = q.pop_front();
                        chk($sformatf("slot%0d_an", slot), 32'(an), 32'(e.an));
                        chk($sformatf("slot%0d_seg", slot), 32'(seg), 32'(e.seg));
                        chk($sformatf("slot%0d_dp", slot), 32'(dp), 32'(e.dp));
                    end
                end
                prev_act = act;
            end
        end
    end

    initial begin
        reset      = 1'b1;
        data_in    = 16'h0000;
        dp_in      = 4'h0;
        data_valid = 1'b0;

        // Frame 0: display 0000
        push(0, A0, S0, 1'b1);
        push(1, A1, LZ, 1'b1);
        push(2, A2, LZ, 1'b1);
        push(3, A3, LZ, 1'b1);
        // Frame 1: 1234
        push(4, A0, S4, 1'b1);
        push(5, A1, S3, 1'b1);
        push(6, A2, S2, 1'b1);
        push(7, A3, S1, 1'b1);
        // Frame 2: 5555 with dp on digits 0 and 2
        push(8,  A0, S5, 1'b0);
        push(9,  A1, S5, 1'b1);
        push(10, A2, S5, 1'b0);
        push(11, A3, S5, 1'b1);
        // Frame 3: BEEF
        push(12, A0, SF, 1'b1);
        push(13, A1, SE, 1'b1);
        push(14, A2, SE, 1'b1);
        push(15, A3, SB, 1'b1);
        // Frame 4: no new value, BEEF held
        push(16, A0, SF, 1'b1);
        push(18, A2, SE, 1'b1);

        repeat (2) @(posedge clk);
        #2;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        @(negedge clk);
        #2;
        reset = 1'b0;

        wait_edge(1);
        chk("blank1_an", 32'(an), 32'hF);
        chk("blank1_frame_done", 32'(frame_done), 32'h0);
        wait_edge(2);
        chk("blank2_seg", 32'(seg), 32'h7F);

        wait_edge(5);
        strobe(16'h1234, 4'h0);
        wait_edge(6);
        data_valid = 1'b0;
        chk("cap_pending", 32'(pending), 32'h1);

        wait_edge(31);
        chk("pre_bnd_pending", 32'(pending), 32'h1);
        chk("pre_bnd_frame_done", 32'(frame_done), 32'h0);
        wait_edge(32);
        chk("bnd1_frame_done", 32'(frame_done), 32'h1);
        chk("bnd1_pending", 32'(pending), 32'h0);
        wait_edge(33);
        chk("bnd1_frame_done_end", 32'(frame_done), 32'h0);

        wait_edge(40);
        strobe(16'hAAAA, 4'h0);
        wait_edge(41);
        data_valid = 1'b0;
        chk("aaaa_pending", 32'(pending), 32'h1);
        wait_edge(50);
        strobe(16'h5555, 4'b0101);
        wait_edge(51);
        data_valid = 1'b0;

        wait_edge(64);
        chk("bnd2_frame_done", 32'(frame_done), 32'h1);
        chk("bnd2_pending", 32'(pending), 32'h0);

        wait_edge(95);
        strobe(16'hBEEF, 4'h0);
        wait_edge(96);
        data_valid = 1'b0;
        chk("bnd3_frame_done", 32'(frame_done), 32'h1);
        chk("bnd3_pending", 32'(pending), 32'h0);

        wait_edge(128);
        chk("bnd4_frame_done", 32'(frame_done), 32'h1);

        // Reset in the middle of the idx=2 slot
        wait_edge(149);
        chk("pre_reset_queue", 32'(q.size()), 32'h0);
        reset = 1'b1;
        #1;
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_dp", 32'(dp), 32'h1);
        chk("midrst_pending", 32'(pending), 32'h0);

        push(0, A0, S0, 1'b1);
        push(4, A0, S2, 1'b1);
        push(5, A1, S4, 1'b1);
        push(6, A2, LZ, 1'b1);
        push(7, A3, LZ, 1'b1);

        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;

        wait_edge(5);
        strobe(16'h0042, 4'h0);
        wait_edge(6);
        data_valid = 1'b0;

        wait_edge(70);
        chk("final_queue", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
